// File: rtl/regfile_dump_reader.sv
// Register-file dump reader: walks FIRST_REG..LAST_REG through a spare
// async read port and streams each word out on a valid/ready handshake.
module regfile_dump_reader #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    DONE
  } state_e;

  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(LAST_REG);
  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

  state_e              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic                busy_q;
  logic                done_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [ADDR_W-1:0]   out_addr_q;
  logic                out_last_q;

  // rd_addr is kept as its own register so it tracks ptr in FETCH/SEND
  // and reads 0 in IDLE/DONE without any combinational decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= FIRST;
      rd_addr_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            ptr_q     <= FIRST;
            rd_addr_q <= FIRST;
            busy_q    <= 1'b1;
            state_q   <= FETCH;
          end
        end
        FETCH: begin
          out_data_q  <= rd_data;
          out_addr_q  <= ptr_q;
          out_last_q  <= (ptr_q == LAST);
          out_valid_q <= 1'b1;
          state_q     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (out_last_q) begin
              rd_addr_q <= '0;
              done_q    <= 1'b1;
              state_q   <= DONE;
            end else begin
              ptr_q     <= ptr_q + ONE;
              rd_addr_q <= ptr_q + ONE;
              state_q   <= FETCH;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_addr   = rd_addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: full-range instance plus a
// two-register (30..31) instance sharing one register-file model.
module tb_regfile_dump_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic        out_ready;
  logic        sel;
  logic [31:0] regs [32];

  logic        start_a, busy_a, done_a, valid_a, last_a;
  logic [4:0]  rd_addr_a, addr_a;
  logic [31:0] rd_data_a, data_a;
  logic        start_b, busy_b, done_b, valid_b, last_b;
  logic [4:0]  rd_addr_b, addr_b;
  logic [31:0] rd_data_b, data_b;

  logic        m_busy, m_done, m_valid, m_last;
  logic [4:0]  m_rd_addr, m_addr;
  logic [31:0] m_data;

  assign start_a   = start & ~sel;
  assign start_b   = start & sel;
  assign rd_data_a = (rd_addr_a == 5'd0) ? 32'd0 : regs[rd_addr_a];
  assign rd_data_b = (rd_addr_b == 5'd0) ? 32'd0 : regs[rd_addr_b];

  assign m_busy    = sel ? busy_b    : busy_a;
  assign m_done    = sel ? done_b    : done_a;
  assign m_valid   = sel ? valid_b   : valid_a;
  assign m_last    = sel ? last_b    : last_a;
  assign m_rd_addr = sel ? rd_addr_b : rd_addr_a;
  assign m_addr    = sel ? addr_b    : addr_a;
  assign m_data    = sel ? data_b    : data_a;

  regfile_dump_reader #(
    .ADDR_W(5), .DATA_W(32), .FIRST_REG(0), .LAST_REG(31)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .busy(busy_a), .done(done_a),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .out_valid(valid_a), .out_ready(out_ready),
    .out_data(data_a), .out_addr(addr_a), .out_last(last_a)
  );

  regfile_dump_reader #(
    .ADDR_W(5), .DATA_W(32), .FIRST_REG(30), .LAST_REG(31)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .busy(busy_b), .done(done_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .out_valid(valid_b), .out_ready(out_ready),
    .out_data(data_b), .out_addr(addr_b), .out_last(last_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic init_regs();
    for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h1111_1111;
  endtask

  // One dump: bp = address to stall 5 cycles on, rs = address at which
  // start is re-pulsed, wr = mid-dump write scenario, cyc = expected
  // posedge count (start edge = 1) at which done is seen.
  task automatic dump(input int first, input int last, input int bp,
                      input int rs, input bit wr, input int cyc);
    int          n, cnt, expa, dones, bp_left;
    bit          bp_done, hold, fin;
    logic [31:0] hd, ew;
    logic [4:0]  ha;
    cnt = 0; expa = first; dones = 0; bp_left = 0;
    bp_done = 0; hold = 0; fin = 0; hd = '0; ha = '0;
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    chk("busy_after_start", m_busy, 1'b1);
    chk("rd_addr_first", m_rd_addr, 32'(first));
    while (n < 300 && !fin) begin
      start = 1'b0;
      if (m_done) begin
        dones++;
        fin = 1;
      end else begin
        if (m_valid && int'(m_addr) == bp && !bp_done && bp_left == 0) begin
          hd = m_data; ha = m_addr; bp_left = 5; hold = 0;
        end
        if (bp_left > 0) begin
          out_ready = 1'b0;
          if (hold) begin
            chk("bp_valid", m_valid, 1'b1);
            chk("bp_data", m_data, hd);
            chk("bp_addr", m_addr, ha);
          end
          hold = 1;
          bp_left--;
          if (bp_left == 0) bp_done = 1;
        end else begin
          out_ready = 1'b1;
        end
        if (m_valid && out_ready) begin
          ew = (wr && expa == 20) ? 32'hDEAD_BEEF : 32'(expa) * 32'h1111_1111;
          chk("word_addr", m_addr, 32'(expa));
          chk("word_data", m_data, ew);
          chk("word_last", m_last, (expa == last) ? 32'd1 : 32'd0);
          cnt++;
          expa++;
        end
        if (m_valid && int'(m_addr) == rs) start = 1'b1;
        if (wr && m_valid && m_addr == 5'd10) regs[20] = 32'hDEAD_BEEF;
        if (wr && m_valid && m_addr == 5'd5)  regs[3]  = 32'h0BAD_F00D;
      end
      if (!fin) begin
        @(posedge clk); #1;
        n++;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("done_cycle", n, 32'(cyc));
    chk("word_count", cnt, 32'(last - first + 1));
    repeat (3) begin
      @(posedge clk); #1;
      if (m_done) dones++;
    end
    chk("done_once", dones, 32'd1);
    chk("idle_busy", m_busy, 1'b0);
    chk("idle_rd_addr", m_rd_addr, 32'd0);
    chk("idle_valid", m_valid, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; sel = 1'b0;
    init_regs();
    #12;
    chk("rst_busy", m_busy, 1'b0);
    chk("rst_done", m_done, 1'b0);
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_last", m_last, 1'b0);
    chk("rst_data", m_data, 32'd0);
    chk("rst_addr", m_addr, 32'd0);
    chk("rst_rd_addr", m_rd_addr, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Reset in the middle of SEND
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_valid", m_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", m_valid, 1'b0);
    chk("midrst_busy", m_busy, 1'b0);
    chk("midrst_done", m_done, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_busy", m_busy, 1'b0);
    chk("postrst_rd_addr", m_rd_addr, 32'd0);
    chk("postrst_valid", m_valid, 1'b0);

    dump(0, 31, -1, -1, 1'b0, 65);
    dump(0, 31, 7, -1, 1'b0, 70);
    dump(0, 31, -1, 12, 1'b0, 65);
    dump(0, 31, -1, -1, 1'b1, 65);
    init_regs();

    sel = 1'b1;
    @(posedge clk); #1;
    dump(30, 31, -1, -1, 1'b0, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
